// File: rtl/bus_dec_pkg.sv
// Shared types, error codes and helpers for the sequential bus decoder.
package bus_dec_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDecode,
    StWait,
    StResp
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  localparam int unsigned MaxSlv = 16;

  function automatic logic [MaxSlv-1:0] onehot(input logic [3:0] idx);
    return MaxSlv'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_addr_match.sv
// Combinational wildcard address matcher; the lowest-indexed hitting slave wins.
module bus_addr_match #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned NUM_SLV = 6,
  parameter logic [NUM_SLV*ADDR_W-1:0] MATCH = 24'hA8_6420,
  parameter logic [NUM_SLV*ADDR_W-1:0] MASK  = 24'hEE_EEEE,
  localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IdxW-1:0]   idx_o
);

  // Walk from the top down so the lowest matching index is written last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (((addr_i ^ MATCH[i*ADDR_W +: ADDR_W]) & MASK[i*ADDR_W +: ADDR_W]) == '0) begin
        hit_o = 1'b1;
        idx_o = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_decoder_seq.sv
// Registered bus decoder: one request at a time, one-hot slave select,
// acknowledge with timeout, and a held response with error code.
module bus_decoder_seq
  import bus_dec_pkg::*;
#(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_SLV = 6,
  parameter logic [NUM_SLV*ADDR_W-1:0] MATCH = 24'hA8_6420,
  parameter logic [NUM_SLV*ADDR_W-1:0] MASK  = 24'hEE_EEEE,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_addr_i,
  output logic [NUM_SLV-1:0]        sel_o,
  input  logic [NUM_SLV-1:0]        slv_ack_i,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_data_o,
  output logic [1:0]                rsp_err_o
);

  localparam int unsigned IdxW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic [TmrW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          err_q, err_d;

  logic                match_hit;
  logic [IdxW-1:0]     match_idx;
  logic                ack;
  logic [DATA_W-1:0]   rdata;

  bus_addr_match #(
    .ADDR_W (ADDR_W),
    .NUM_SLV(NUM_SLV),
    .MATCH  (MATCH),
    .MASK   (MASK)
  ) u_match (
    .addr_i(addr_q),
    .hit_o (match_hit),
    .idx_o (match_idx)
  );

  // Only the registered winner's ack and data are ever looked at.
  assign ack   = slv_ack_i[idx_q];
  assign rdata = slv_rdata_i[idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (match_hit) begin
          idx_d   = match_idx;
          sel_d   = NUM_SLV'(onehot(4'(match_idx)));
          timer_d = '0;
          state_d = StWait;
        end else begin
          err_d   = ERR_UNMAPPED;
          data_d  = '0;
          state_d = StResp;
        end
      end
      StWait: begin
        if (ack) begin
          data_d  = rdata;
          err_d   = ERR_OK;
          sel_d   = '0;
          state_d = StResp;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = ERR_TIMEOUT;
          sel_d   = '0;
          state_d = StResp;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign sel_o       = sel_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_bus_decoder_seq.sv
// Self-checking bench for bus_decoder_seq: transaction-level model plus
// directed vectors with hand-computed results.
module tb_bus_decoder_seq;

  localparam int TIMEOUT = 15;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_addr;
  logic [5:0]  sel;
  logic [5:0]  slv_ack;
  logic [47:0] slv_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // slave responder configuration (written by the main sequence only)
  int ack_slv   = 0;
  int ack_after = 0;
  bit spam_en   = 0;
  int spam_slv  = 0;
  int sel_run   = 0;
  int sel_hi    = 0;

  bus_decoder_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .sel_o      (sel),
    .slv_ack_i  (slv_ack),
    .slv_rdata_i(slv_rdata),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Default table: slave i matches value i*2 with bit 0 as don't-care.
  function automatic int decode(input logic [3:0] a);
    for (int i = 0; i < 6; i++) begin
      if ((a & 4'hE) == (4'(i * 2) & 4'hE)) return i;
    end
    return -1;
  endfunction

  // Transaction-level model of what the master and slaves should observe.
  logic       m_ready, m_rv, m_decode;
  logic [5:0] m_sel;
  logic [7:0] m_data;
  logic [1:0] m_err;
  logic [3:0] m_addr;
  int         m_slave, m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  <= 1'b1;
      m_rv     <= 1'b0;
      m_decode <= 1'b0;
      m_sel    <= '0;
      m_data   <= '0;
      m_err    <= 2'b00;
      m_addr   <= '0;
      m_slave  <= 0;
      m_cnt    <= 0;
    end else if (m_rv) begin
      if (rsp_ready) begin
        m_rv    <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_sel != 0) begin
      if (slv_ack[m_slave]) begin
        m_rv   <= 1'b1;
        m_data <= slv_rdata[m_slave*8 +: 8];
        m_err  <= 2'b00;
        m_sel  <= '0;
      end else if (m_cnt == TIMEOUT) begin
        m_rv   <= 1'b1;
        m_data <= '0;
        m_err  <= 2'b10;
        m_sel  <= '0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (m_decode) begin
      m_decode <= 1'b0;
      if (decode(m_addr) < 0) begin
        m_rv   <= 1'b1;
        m_data <= '0;
        m_err  <= 2'b01;
      end else begin
        m_slave <= decode(m_addr);
        m_sel   <= 6'(1) << decode(m_addr);
        m_cnt   <= 1;
      end
    end else if (m_ready && req_valid) begin
      m_addr   <= req_addr;
      m_decode <= 1'b1;
      m_ready  <= 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("req_ready", 32'(req_ready), 32'(m_ready));
    check("sel", 32'(sel), 32'(m_sel));
    check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      check("rsp_data", 32'(rsp_data), 32'(m_data));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    if (sel != 0) sel_hi = sel_hi + 1;
  end

  // Slave responders: ack_slv acks on its ack_after-th selected cycle (0 = never).
  always @(negedge clk) begin
    slv_ack = '0;
    if (spam_en) slv_ack[spam_slv] = 1'b1;
    if (sel[ack_slv]) begin
      sel_run = sel_run + 1;
      if (ack_after != 0 && sel_run == ack_after) slv_ack[ack_slv] = 1'b1;
    end else begin
      sel_run = 0;
    end
  end

  task automatic run_req(input logic [3:0] addr, input int aslv, input int aafter,
                         input bit spam, input int hold, input logic [5:0] exp_sel,
                         input int exp_cycles, input int exp_lat, input logic [7:0] exp_data,
                         input logic [1:0] exp_err, input string tag);
    int         lat;
    int         hi0;
    logic [5:0] sel_or;
    logic [7:0] d0;
    logic [1:0] e0;
    ack_slv   = aslv;
    ack_after = aafter;
    spam_en   = spam;
    spam_slv  = 3;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " ready_at_start"}, 32'(req_ready), 32'd1);
    hi0       = sel_hi;
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~addr;
    lat    = 0;
    sel_or = '0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      sel_or |= sel;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " sel_onehot"}, 32'(sel_or), 32'(exp_sel));
    check({tag, " sel_cycles"}, 32'(sel_hi - hi0), 32'(exp_cycles));
    check({tag, " data"}, 32'(rsp_data), 32'(exp_data));
    check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    d0 = rsp_data;
    e0 = rsp_err;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1;
      req_addr  = 4'b0000;
      @(negedge clk);
      check({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " hold_data"}, 32'(rsp_data), 32'(d0));
      check({tag, " hold_err"}, 32'(rsp_err), 32'(e0));
      check({tag, " hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    spam_en   = 1'b0;
    check({tag, " ready_after"}, 32'(req_ready), 32'd1);
    check({tag, " valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    slv_ack   = '0;
    slv_rdata = {8'h3C, 8'hE1, 8'h77, 8'hC3, 8'h5A, 8'hA5};
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst sel", 32'(sel), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_data", 32'(rsp_data), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_req(4'b0000, 0, 1, 1'b0, 0, 6'b000001, 1, 2, 8'hA5, 2'b00, "s0_ack1");
    run_req(4'b1011, 5, 3, 1'b0, 5, 6'b100000, 3, 4, 8'h3C, 2'b00, "s5_ack3_bp");
    run_req(4'b1111, 0, 0, 1'b0, 0, 6'b000000, 0, 1, 8'h00, 2'b01, "unmapped");
    run_req(4'b0100, 2, 0, 1'b1, 0, 6'b000100, 15, 16, 8'h00, 2'b10, "timeout");
    run_req(4'b1001, 4, 15, 1'b0, 0, 6'b010000, 15, 16, 8'hE1, 2'b00, "ack_last");

    // Reset in the middle of a WAIT on slave1, which never acks.
    ack_slv   = 1;
    ack_after = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 4'b0010;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midwait sel", 32'(sel), 32'h02);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async sel", 32'(sel), 32'd0);
    check("async rsp_valid", 32'(rsp_valid), 32'd0);
    check("async req_ready", 32'(req_ready), 32'd1);
    check("async rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(4'b0011, 1, 2, 1'b0, 0, 6'b000010, 2, 3, 8'h5A, 2'b00, "post_reset");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
